// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit unsigned MAC datapath (unsigned_mult + mult_accumulator).
package mult_pkg;

  // Default datapath width, shared with unsigned_mult's result width.
  localparam int WIDTH = 8;

  // Accumulator frame state: collecting products, or holding a finished sum.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/sat_adder.sv
// Combinational WIDTH-bit adder with a carry-out and an optional saturating mode.
module sat_adder #(
  parameter int WIDTH = 8,
  parameter int SAT   = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] wide;

  // Add with one extra bit. On carry, either wrap or clamp to all-ones.
  // With SAT=1, an all-ones input plus any nonzero value carries again,
  // so a saturated accumulator stays at all-ones for the rest of the frame.
  always_comb begin
    wide  = {1'b0, a} + {1'b0, b};
    carry = wide[WIDTH];
    if ((SAT != 0) && wide[WIDTH]) begin
      sum = '1;
    end else begin
      sum = wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_accumulator.sv
// Accumulates COUNT products into one frame sum with a sticky overflow flag,
// then offers the sum downstream.
//
// Handshakes: a word moves across an interface exactly at a rising edge where
// valid && ready are both 1. The sender holds its valid and data steady until
// that edge. in_ready is combinational: it depends on state, rst and clear only.
// out_valid and the output data come straight from registers.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int COUNT = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] prod,
  input  logic             prod_of,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_of
);

  localparam logic [7:0] LAST = 8'(COUNT - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [7:0]       cnt;
  logic             of_sticky;

  logic [WIDTH-1:0] next_acc;
  logic             carry;
  logic             accept;

  sat_adder #(
    .WIDTH(WIDTH),
    .SAT  (SAT)
  ) u_add (
    .a    (acc),
    .b    (prod),
    .sum  (next_acc),
    .carry(carry)
  );

  // Input handshake and output view of the registered frame result.
  // rst and clear close the input port in their own cycle.
  always_comb begin
    in_ready  = (state == ACC) && !clear && !rst;
    accept    = in_valid && in_ready;
    out_valid = (state == HOLD);
    out_data  = out_valid ? acc : '0;
    out_of    = out_valid ? of_sticky : 1'b0;
  end

  // Frame FSM. rst and clear abort everything. In ACC, each accept adds a
  // product; the last one moves to HOLD. In HOLD, a downstream take starts a new frame.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      of_sticky <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc       <= next_acc;
            of_sticky <= of_sticky | prod_of | carry;
            cnt       <= cnt + 8'd1;
            if (cnt == LAST) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            of_sticky <= 1'b0;
          end
        end
        default: begin
          state <= ACC;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
- Downstream consumer of the combinational unsigned_mult stage.
- Accepts a stream of WIDTH-bit products plus per-product overflow flags over a valid/ready handshake.
- Accumulates COUNT products into one frame sum with a sticky overflow flag, then presents the sum downstream over a second valid/ready handshake.
- Forms the accumulate half of an 8-bit unsigned MAC datapath.

Parameters:
- WIDTH, 8: product and accumulator width in bits; matches the unsigned_mult result width.
- COUNT, 4: products per frame; legal range 1..255.
- SAT, 0: 0 = accumulator wraps modulo 2^WIDTH on carry; 1 = accumulator saturates at all-ones.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous frame abort; same effect as rst on internal state.
- in_valid  in  1  product word is valid.
- in_ready  out  1  block can accept a product this cycle.
- prod  in  WIDTH  product from unsigned_mult (its result output).
- prod_of  in  1  overflow flag from unsigned_mult (its of output).
- out_valid  out  1  frame sum is available.
- out_ready  in  1  downstream accepts the frame sum.
- out_data  out  WIDTH  accumulated frame sum.
- out_of  out  1  sticky overflow for the frame.

Behaviour:
- Reset (rst=1 at an edge), from any state, including mid-frame or while holding a result:
  - state=ACC, acc=0, cnt=0, of_sticky=0.
  - out_valid=0, out_data=0, out_of=0.
  - in_ready reads 1 in the first cycle after reset.
- clear=1: identical effect to rst on the next edge. Both rst and clear take priority over every handshake that cycle.
- in_ready is combinational: (state==ACC) && !clear && !rst.
- State ACC:
  - An accept is in_valid && in_ready at a rising edge.
  - On accept, form sum = {1'b0,acc} + {1'b0,prod}, which is WIDTH+1 bits wide.
  - of_sticky <= of_sticky | prod_of | sum[WIDTH].
  - If sum[WIDTH] is 0, acc <= sum[WIDTH-1:0].
  - If sum[WIDTH] is 1 and SAT=0, acc <= sum[WIDTH-1:0], i.e. it wraps.
  - If sum[WIDTH] is 1 and SAT=1, acc <= all-ones.
  - Once saturated, acc stays all-ones for the rest of the frame.
  - cnt <= cnt+1 on each accept.
  - When the accept is the one with cnt==COUNT-1, go to HOLD.
  - The prod value is added even when prod_of=1; the only extra effect of prod_of is to set the flag.
- State HOLD:
  - out_valid=1, in_ready=0.
  - out_data = acc and out_of = of_sticky, both taken from the registered values, which include the final product.
  - out_valid rises on the cycle after the final accept; input-to-output latency is 1 cycle.
  - out_data and out_of stay stable while out_valid=1 and out_ready=0.
  - in_valid is ignored in HOLD; upstream must hold its word.
- Frame completion: out_valid && out_ready at an edge clears acc, cnt and of_sticky and returns to ACC.
  - out_valid=0 in the next cycle; there is no cut-through of a new product in the same cycle.
- out_data and out_of read 0 whenever out_valid=0.
- COUNT=1: every accept goes straight to HOLD.
- Throughput: COUNT+1 cycles per frame minimum, with out_ready tied high.

Decomposition:
- Shared package mult_pkg holds:
  - the WIDTH default constant (8), shared with unsigned_mult;
  - the state typedef {ACC, HOLD}.
- One sub-module, sat_adder (WIDTH, SAT):
  - purely combinational;
  - inputs a and b;
  - outputs sum[WIDTH-1:0] and carry.
- The top level holds the FSM, counter, sticky flag and handshakes.

Test Plan:
- COUNT=4, SAT=0; prod 0x10, 0x20, 0x30, 0x40 on consecutive cycles; out_ready=1 -> out_valid on the cycle after the 4th accept, out_data=0xA8? No: 0x10+0x20+0x30+0x40 = 0xA0, out_of=0; in_ready=1 again one cycle later.
- SAT=0; prod 0xA8 (42*4), 0x98 (2*76), 0x00, 0x00 -> out_data=0x40, out_of=1. The same stimulus with SAT=1 -> out_data=0xFF, out_of=1.
- prod 0x00 with prod_of=1 (128*4), then 0x01, 0x01, 0x01 -> out_data=0x03, out_of=1.
- Backpressure: at frame end, hold out_ready=0 for 5 cycles while pulsing in_valid with 0x55 -> out_valid stays 1, out_data is stable, in_ready=0, 0x55 is never added. Then raise out_ready -> next frame starts from acc=0.
- rst=1 for one cycle after 2 accepts (0x11, 0x22) -> all outputs 0. The next 4 products 0x01 each -> out_data=0x04, out_of=0.
- clear=1 in the same cycle as in_valid with prod=0x7F -> in_ready=0 in that cycle, no accept, cnt=0. A subsequent frame with no clear sums correctly.
